// File: rtl/cpu_types_pkg.sv
// Basic CPU word and register-index types.
package cpu_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;

endpackage

// File: rtl/memory_stage_pkg.sv
// Pipeline bundles and FSM state for the memory stage.
// LL/SC support is built only when LLSC_EN is defined.
package memory_stage_pkg;
  import cpu_types_pkg::*;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  typedef struct packed {
    word_t      pc;
    regbits_t   rd;
    logic       reg_wen;
    logic       mem_ren;
    logic       mem_wen;
    word_t      alu_out;
    word_t      store_data;
    logic [1:0] wb_sel;
    logic       halt;
    logic       ll;
    logic       sc;
  } execute_t;

  typedef struct packed {
    word_t      pc;
    regbits_t   rd;
    logic       reg_wen;
    word_t      alu_out;
    word_t      load_data;
    logic [1:0] wb_sel;
    logic       halt;
  } memory_t;

  // A halted instruction never touches the data cache.
  function automatic logic needs_dcache(execute_t e);
    return (e.mem_ren | e.mem_wen) & ~e.halt;
  endfunction

endpackage

// File: rtl/memory_stage_if.sv
// Execute-to-writeback bus of the memory stage, including the data-cache port.
// Snoop inputs (ccinv, ccsnoopaddr) exist only when LLSC_EN is defined.
interface memory_stage_if;
  import cpu_types_pkg::*;
  import memory_stage_pkg::*;

  // Handshake: dmemREN/dmemWEN stay high until the cycle dhit is seen; dhit
  // completes the request in that same cycle and the request drops after it.
  execute_t   execute_p;
  logic       ihit;
  logic       dhit;
  logic       flush;
  logic       stall;
  word_t      dmemload;
  logic       dmemREN;
  logic       dmemWEN;
  word_t      dmemaddr;
  word_t      dmemstore;
  logic       mem_busy;
  memory_t    memory_p;
  mem_state_t state;
`ifdef LLSC_EN
  logic       ccinv;
  word_t      ccsnoopaddr;
`endif

  modport master (
    input  execute_p, ihit, dhit, flush, stall, dmemload,
`ifdef LLSC_EN
    input  ccinv, ccsnoopaddr,
`endif
    output dmemREN, dmemWEN, dmemaddr, dmemstore, mem_busy, memory_p, state
  );

  modport slave (
    output execute_p, ihit, dhit, flush, stall, dmemload,
`ifdef LLSC_EN
    output ccinv, ccsnoopaddr,
`endif
    input  dmemREN, dmemWEN, dmemaddr, dmemstore, mem_busy, memory_p, state
  );

endinterface

// File: rtl/memory_link_reg.sv
// LL/SC link register: tracks one reserved word address and reports whether
// an address matches the reservation as it will stand after this edge.
module memory_link_reg
  import cpu_types_pkg::*;
#(
  parameter int WORD_ALIGN_BITS = 2
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  set_i,
  input  logic  store_i,
  input  logic  clr_i,
  input  word_t addr_i,
  input  logic  inv_i,
  input  word_t inv_addr_i,
  input  word_t cmp_addr_i,
  output logic  match_o
);

  localparam int TAG_W = 32 - WORD_ALIGN_BITS;
  typedef logic [TAG_W-1:0] tag_t;

  logic valid_q, valid_d;
  tag_t tag_q, tag_d;

  function automatic tag_t tag_of(word_t a);
    return a[31:WORD_ALIGN_BITS];
  endfunction

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    if (set_i) begin
      valid_d = 1'b1;
      tag_d   = tag_of(addr_i);
    end
    if (clr_i || (store_i && tag_of(addr_i) == tag_d)) valid_d = 1'b0;
    if (inv_i && tag_of(inv_addr_i) == tag_d)           valid_d = 1'b0;
  end

  // Compare against the next state so an SC advancing on the same edge as a
  // completing LL, store or snoop sees the up-to-date reservation.
  assign match_o = valid_d && (tag_of(cmp_addr_i) == tag_d);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
    end
  end

  logic unused_lsb;
  assign unused_lsb = ^{addr_i[WORD_ALIGN_BITS-1:0], inv_addr_i[WORD_ALIGN_BITS-1:0],
                        cmp_addr_i[WORD_ALIGN_BITS-1:0]};

endmodule

// File: rtl/memory_stage.sv
// Memory pipeline stage: EX/MEM register plus data-cache request sequencer.
// Define LLSC_EN to build load-linked / store-conditional support.
module memory_stage
  import cpu_types_pkg::*;
  import memory_stage_pkg::*;
#(
  parameter int WORD_ALIGN_BITS = 2
) (
  input logic            CLK,
  input logic            RST,
  memory_stage_if.master mif
);

  execute_t   ex_q;
  mem_state_t state_q;
  word_t      load_q;

  logic  in_req;
  logic  rd_req;
  logic  wr_req;
  logic  mem_busy;
  logic  advance;
  logic  sc_fail;
  word_t hit_data;
  word_t dmemaddr;
  word_t load_data;

  assign in_req   = (state_q == REQ);
  assign rd_req   = in_req & ex_q.mem_ren & ~ex_q.halt;
  // Read wins when both enables are set.
  assign wr_req   = in_req & ex_q.mem_wen & ~ex_q.mem_ren & ~ex_q.halt;
  assign mem_busy = in_req & ~mif.dhit;
  assign advance  = mif.ihit & ~mem_busy;
  assign dmemaddr = {ex_q.alu_out[31:WORD_ALIGN_BITS], {WORD_ALIGN_BITS{1'b0}}};

`ifdef LLSC_EN
  logic link_match;

  memory_link_reg #(
    .WORD_ALIGN_BITS(WORD_ALIGN_BITS)
  ) u_link (
    .clk_i      (CLK),
    .rst_i      (RST),
    .set_i      (rd_req & mif.dhit & ex_q.ll),
    .store_i    (wr_req & mif.dhit),
    .clr_i      (wr_req & mif.dhit & ex_q.sc),
    .addr_i     (dmemaddr),
    .inv_i      (mif.ccinv),
    .inv_addr_i (mif.ccsnoopaddr),
    .cmp_addr_i (mif.execute_p.alu_out),
    .match_o    (link_match)
  );

  assign sc_fail  = mif.execute_p.sc & ~link_match;
  // A successful SC reports 1 to writeback instead of cache data.
  assign hit_data = ex_q.sc ? 32'd1 : mif.dmemload;
`else
  logic unused_llsc;
  assign unused_llsc = ex_q.ll ^ ex_q.sc;
  assign sc_fail     = 1'b0;
  assign hit_data    = mif.dmemload;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      ex_q    <= '0;
      state_q <= IDLE;
      load_q  <= '0;
    end else if (mif.flush) begin
      ex_q    <= '0;
      state_q <= IDLE;
      load_q  <= '0;
    end else if (mif.stall || !advance) begin
      // Register held, but a completing request must retire so it is not re-issued.
      if (in_req && mif.dhit) begin
        state_q <= DONE;
        load_q  <= hit_data;
      end
    end else begin
      ex_q <= mif.execute_p;
      if (!needs_dcache(mif.execute_p)) begin
        state_q <= IDLE;
      end else if (sc_fail) begin
        state_q <= DONE;
        load_q  <= '0;
      end else begin
        state_q <= REQ;
      end
    end
  end

  always_comb begin
    load_data = '0;
    if (state_q == DONE)          load_data = load_q;
    else if (in_req && mif.dhit)  load_data = hit_data;
  end

  assign mif.dmemREN   = rd_req;
  assign mif.dmemWEN   = wr_req;
  assign mif.dmemaddr  = dmemaddr;
  assign mif.dmemstore = ex_q.store_data;
  assign mif.mem_busy  = mem_busy;
  assign mif.state     = state_q;

  always_comb begin
    mif.memory_p           = '0;
    mif.memory_p.pc        = ex_q.pc;
    mif.memory_p.rd        = ex_q.rd;
    mif.memory_p.reg_wen   = ex_q.reg_wen;
    mif.memory_p.alu_out   = ex_q.alu_out;
    mif.memory_p.load_data = load_data;
    mif.memory_p.wb_sel    = ex_q.wb_sel;
    mif.memory_p.halt      = ex_q.halt;
  end

endmodule

// File: tb/tb_memory_stage.sv
// Directed self-checking bench for memory_stage; LL/SC cases run when LLSC_EN is defined.
module tb_memory_stage;
  import cpu_types_pkg::*;
  import memory_stage_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [31:0] exp_q[$];

  memory_stage_if mif();

  memory_stage #(.WORD_ALIGN_BITS(2)) dut (
    .CLK (clk),
    .RST (rst),
    .mif (mif)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Checking
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic chk_ld(input string tag);
    logic [31:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
    chk(tag, mif.memory_p.load_data, e);
  endtask

  // Driver helpers
  function automatic execute_t op(input word_t pc, input logic ren, input logic wen,
                                  input word_t alu, input word_t sd, input logic halt,
                                  input logic ll, input logic sc);
    execute_t e;
    e            = '0;
    e.pc         = pc;
    e.rd         = 5'd3;
    e.reg_wen    = ~wen | sc;
    e.mem_ren    = ren;
    e.mem_wen    = wen;
    e.alu_out    = alu;
    e.store_data = sd;
    e.wb_sel     = ren ? 2'd1 : 2'd0;
    e.halt       = halt;
    e.ll         = ll;
    e.sc         = sc;
    return e;
  endfunction

  task automatic drive(input execute_t e, input logic ihit, input logic dhit, input word_t load);
    mif.execute_p = e;
    mif.ihit      = ihit;
    mif.dhit      = dhit;
    mif.dmemload  = load;
  endtask

  initial begin
    mif.execute_p = '0;
    mif.ihit      = 1'b0;
    mif.dhit      = 1'b0;
    mif.flush     = 1'b0;
    mif.stall     = 1'b0;
    mif.dmemload  = '0;
`ifdef LLSC_EN
    mif.ccinv       = 1'b0;
    mif.ccsnoopaddr = '0;
`endif
    step();
    step();
    settle();
    chk("rst_memory_p", {31'd0, |mif.memory_p}, 32'd0);
    chk("rst_ren", {31'd0, mif.dmemREN}, 32'd0);
    chk("rst_wen", {31'd0, mif.dmemWEN}, 32'd0);
    chk("rst_busy", {31'd0, mif.mem_busy}, 32'd0);

    // Load, dhit on third request cycle, stall held while it completes
    rst = 1'b0;
    drive(op(32'h40, 1, 0, 32'h103, 32'h0, 0, 0, 0), 1, 0, 32'h0);
    step();
    drive(op(32'h44, 0, 1, 32'h302, 32'h1234, 0, 0, 0), 1, 0, 32'h0);
    settle();
    chk("ld_addr", mif.dmemaddr, 32'h100);
    chk("ld_ren_c1", {31'd0, mif.dmemREN}, 32'd1);
    chk("ld_busy_c1", {31'd0, mif.mem_busy}, 32'd1);
    chk("ld_pc", mif.memory_p.pc, 32'h40);
    step();
    settle();
    chk("ld_ren_c2", {31'd0, mif.dmemREN}, 32'd1);
    chk("ld_busy_c2", {31'd0, mif.mem_busy}, 32'd1);
    step();
    mif.stall = 1'b1;
    mif.dhit = 1'b1;
    mif.dmemload = 32'hDEADBEEF;
    exp_q.push_back(32'hDEADBEEF);
    exp_q.push_back(32'hDEADBEEF);
    exp_q.push_back(32'hDEADBEEF);
    settle();
    chk("ld_ren_c3", {31'd0, mif.dmemREN}, 32'd1);
    chk("ld_busy_c3", {31'd0, mif.mem_busy}, 32'd0);
    chk_ld("ld_bypass");
    step();
    mif.dmemload = 32'h0000_0BAD;
    settle();
    chk("ld_ren_drop", {31'd0, mif.dmemREN}, 32'd0);
    chk("ld_busy_done", {31'd0, mif.mem_busy}, 32'd0);
    chk_ld("ld_held_dhit_ignored");
    step();
    mif.stall = 1'b0;
    mif.dhit = 1'b0;
    settle();
    chk("ld_no_reissue", {31'd0, mif.dmemREN}, 32'd0);
    chk("ld_pc_held", mif.memory_p.pc, 32'h44 - 32'h4);
    chk_ld("ld_done_data");

    // Store with dhit in its first cycle, then back-to-back load
    step();
    drive(op(32'h48, 1, 0, 32'h20C, 32'h0, 0, 0, 0), 1, 1, 32'h5555);
    settle();
    chk("st_wen", {31'd0, mif.dmemWEN}, 32'd1);
    chk("st_ren", {31'd0, mif.dmemREN}, 32'd0);
    chk("st_addr", mif.dmemaddr, 32'h300);
    chk("st_data", mif.dmemstore, 32'h1234);
    chk("st_busy", {31'd0, mif.mem_busy}, 32'd0);
    step();
    drive(op(32'h4C, 0, 0, 32'h11, 32'h0, 0, 0, 0), 1, 1, 32'hCAFE0001);
    exp_q.push_back(32'hCAFE0001);
    settle();
    chk("b2b_pc", mif.memory_p.pc, 32'h48);
    chk("b2b_wen", {31'd0, mif.dmemWEN}, 32'd0);
    chk("b2b_ren", {31'd0, mif.dmemREN}, 32'd1);
    chk("b2b_addr", mif.dmemaddr, 32'h20C);
    chk_ld("b2b_data");
    step();
    mif.dhit = 1'b0;
    settle();
    chk("nop_pc", mif.memory_p.pc, 32'h4C);
    chk("nop_ren", {31'd0, mif.dmemREN}, 32'd0);
    chk("nop_load", mif.memory_p.load_data, 32'h0);

    // Halted load issues nothing; read+write issues the read only
    drive(op(32'h50, 1, 0, 32'h600, 32'h0, 1, 0, 0), 1, 0, 32'h0);
    step();
    settle();
    chk("halt_ren", {31'd0, mif.dmemREN}, 32'd0);
    chk("halt_busy", {31'd0, mif.mem_busy}, 32'd0);
    chk("halt_flag", {31'd0, mif.memory_p.halt}, 32'd1);
    drive(op(32'h54, 1, 1, 32'h700, 32'h9, 0, 0, 0), 1, 0, 32'h0);
    step();
    settle();
    chk("rw_ren", {31'd0, mif.dmemREN}, 32'd1);
    chk("rw_wen", {31'd0, mif.dmemWEN}, 32'd0);
    chk("rw_busy", {31'd0, mif.mem_busy}, 32'd1);

    // Flush mid-request
    drive(op(32'h58, 1, 0, 32'h404, 32'h0, 0, 0, 0), 1, 1, 32'h1);
    step();
    mif.dhit = 1'b0;
    settle();
    chk("fl_ren_before", {31'd0, mif.dmemREN}, 32'd1);
    chk("fl_addr", mif.dmemaddr, 32'h404);
    mif.flush = 1'b1;
    step();
    drive(op(32'h5C, 0, 0, 32'h0, 32'h0, 0, 0, 0), 0, 1, 32'h77);
    mif.flush = 1'b0;
    settle();
    chk("fl_ren_after", {31'd0, mif.dmemREN}, 32'd0);
    chk("fl_busy", {31'd0, mif.mem_busy}, 32'd0);
    chk("fl_bubble_pc", mif.memory_p.pc, 32'h0);
    chk("fl_bubble_load", mif.memory_p.load_data, 32'h0);
    step();
    mif.dhit = 1'b0;
    settle();
    chk("fl_late_dhit", mif.memory_p.load_data, 32'h0);
    chk("fl_state_idle", {30'd0, mif.state}, {30'd0, IDLE});

    // Stall holds; flush beats stall
    drive(op(32'h80, 0, 0, 32'h55, 32'h0, 0, 0, 0), 1, 0, 32'h0);
    step();
    drive(op(32'h84, 0, 0, 32'h66, 32'h0, 0, 0, 0), 1, 0, 32'h0);
    mif.stall = 1'b1;
    settle();
    chk("stl_pc_loaded", mif.memory_p.pc, 32'h80);
    step();
    settle();
    chk("stl_pc_held", mif.memory_p.pc, 32'h80);
    chk("stl_alu_held", mif.memory_p.alu_out, 32'h55);
    mif.flush = 1'b1;
    step();
    mif.flush = 1'b0;
    mif.stall = 1'b0;
    mif.ihit = 1'b0;
    settle();
    chk("fs_pc", mif.memory_p.pc, 32'h0);
    chk("fs_alu", mif.memory_p.alu_out, 32'h0);
    chk("fs_reg_wen", {31'd0, mif.memory_p.reg_wen}, 32'd0);

`ifdef LLSC_EN
    // LL, snoop invalidation, failing SC
    drive(op(32'h90, 1, 0, 32'h200, 32'h0, 0, 1, 0), 1, 0, 32'h0);
    step();
    drive(op(32'h94, 0, 0, 32'h0, 32'h0, 0, 0, 0), 1, 1, 32'hAB);
    settle();
    chk("ll_ren", {31'd0, mif.dmemREN}, 32'd1);
    step();
    drive(op(32'h98, 0, 0, 32'h0, 32'h0, 0, 0, 0), 1, 0, 32'h0);
    mif.ccinv = 1'b1;
    mif.ccsnoopaddr = 32'h200;
    step();
    mif.ccinv = 1'b0;
    drive(op(32'h9C, 0, 1, 32'h200, 32'h1, 0, 0, 1), 1, 0, 32'h0);
    step();
    mif.ihit = 1'b0;
    settle();
    chk("scf_wen", {31'd0, mif.dmemWEN}, 32'd0);
    chk("scf_busy", {31'd0, mif.mem_busy}, 32'd0);
    chk("scf_load", mif.memory_p.load_data, 32'h0);

    // LL, no snoop, succeeding SC
    drive(op(32'hA0, 1, 0, 32'h200, 32'h0, 0, 1, 0), 1, 0, 32'h0);
    step();
    drive(op(32'hA4, 0, 0, 32'h0, 32'h0, 0, 0, 0), 1, 1, 32'hAB);
    step();
    drive(op(32'hA8, 0, 1, 32'h203, 32'h1, 0, 0, 1), 1, 0, 32'h0);
    step();
    mif.ihit = 1'b0;
    settle();
    chk("scs_wen", {31'd0, mif.dmemWEN}, 32'd1);
    chk("scs_busy", {31'd0, mif.mem_busy}, 32'd1);
    chk("scs_addr", mif.dmemaddr, 32'h200);
    mif.dhit = 1'b1;
    mif.dmemload = 32'h0;
    settle();
    chk("scs_load_hit", mif.memory_p.load_data, 32'h1);
    step();
    mif.dhit = 1'b0;
    settle();
    chk("scs_load_done", mif.memory_p.load_data, 32'h1);
    chk("scs_wen_drop", {31'd0, mif.dmemWEN}, 32'd0);

    // Reservation consumed: a second SC fails
    drive(op(32'hAC, 0, 1, 32'h200, 32'h1, 0, 0, 1), 1, 0, 32'h0);
    step();
    mif.ihit = 1'b0;
    settle();
    chk("sc2_wen", {31'd0, mif.dmemWEN}, 32'd0);
    chk("sc2_load", mif.memory_p.load_data, 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the summary in time");
    $fatal(1);
  end

endmodule
